// File: rtl/shake128_arbiter.sv
// -----------------------------------------------------------------------------
// shake128_arbiter
//   Round-robin arbiter / job sequencer sharing one shake128_top core between
//   NUM_REQ requesters. A grant covers a whole job (absorb + squeeze). Between
//   jobs the core's active-low reset is pulsed for CLR_CYCLES cycles.
//
//   Optional feature: define SHAKE_ARB_TIMEOUT_EN to enable the idle-grant
//   timeout (TIMEOUT cycles without a handshake drops the grant and sets a
//   sticky o_timeout flag). Without it o_timeout is tied to 0.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req/i_valid/i_last/   per-requester request and absorb/squeeze handshakes
//   i_ack/i_data
//   o_gnt                   registered one-hot grant
//   o_ready/o_valid         per-requester absorb ready / squeeze valid
//   o_data/o_squeeze        core squeeze data and mode, broadcast
//   o_busy                  high in GRANT or CLEAR
//   o_timeout               sticky per-requester timeout flags
//   o_core_*                drives to the core; i_core_* returns from it
// -----------------------------------------------------------------------------
module shake128_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*64-1:0] i_data,
    input  logic [NUM_REQ-1:0]    i_valid,
    input  logic [NUM_REQ-1:0]    i_last,
    input  logic [NUM_REQ-1:0]    i_ack,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_ready,
    output logic [127:0]          o_data,
    output logic [NUM_REQ-1:0]    o_valid,
    output logic                  o_squeeze,
    output logic                  o_busy,
    output logic [NUM_REQ-1:0]    o_timeout,
    output logic                  o_core_rst_n,
    output logic [63:0]           o_core_data,
    output logic                  o_core_valid,
    output logic                  o_core_last,
    output logic                  o_core_ack,
    input  logic                  i_core_ready,
    input  logic [127:0]          i_core_data,
    input  logic                  i_core_valid,
    input  logic                  i_core_squeeze
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [1:0] {S_CLEAR, S_ARB, S_GRANT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 core_rst_n_q, core_rst_n_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic                 granted_req;
    logic                 tmo_fire;

    assign granted_req = |(gnt_q & i_req);

    // ---------------------------------------------------------------- timeout
`ifdef SHAKE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0] tmo_flag_q, tmo_flag_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               handshake;

    assign handshake = (o_core_valid & i_core_ready) | (o_core_ack & i_core_valid);

    always_comb begin
        tmo_cnt_d = '0;
        tmo_fire  = 1'b0;
        if (state_q == S_GRANT) begin
            if (handshake) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                // TIMEOUT-th consecutive idle GRANT cycle: drop on this edge
                tmo_fire = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
        tmo_flag_d = tmo_flag_q | (tmo_fire ? gnt_q : '0);
        // a timed-out requester stays masked until it lowers i_req
        mask_d     = (mask_q | (tmo_fire ? gnt_q : '0)) & i_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= '0;
            mask_q     <= '0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
            mask_q     <= mask_d;
        end
    end

    assign eligible  = i_req & ~mask_q;
    assign o_timeout = tmo_flag_q;
`else
    assign tmo_fire  = 1'b0;
    assign eligible  = i_req;
    assign o_timeout = '0;
`endif

    // ------------------------------------------------------ round-robin pick
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
        win_oh[win_idx] = win_found;
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= CNT_W'(CLR_CYCLES);
            ptr_q        <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        case (state_q)
            S_CLEAR: begin
                gnt_d = '0;
                if (clr_cnt_q <= CNT_W'(1)) state_d = S_ARB;
                else                        clr_cnt_d = clr_cnt_q - 1'b1;
            end
            S_ARB: begin
                if (win_found) begin
                    gnt_d   = win_oh;
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!granted_req || tmo_fire) begin
                    gnt_d     = '0;
                    clr_cnt_d = CNT_W'(CLR_CYCLES);
                    state_d   = S_CLEAR;
                end
            end
            default: begin
                gnt_d     = '0;
                clr_cnt_d = CNT_W'(CLR_CYCLES);
                state_d   = S_CLEAR;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // busy and core reset are registered from the next state so they change
    // on the same edge as the grant, glitch-free.
    always_comb begin
        busy_d       = (state_d != S_ARB);
        core_rst_n_d = (state_d != S_CLEAR);
        o_core_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) o_core_data = o_core_data | i_data[k*64 +: 64];
        end
    end

    assign o_gnt        = gnt_q;
    assign o_busy       = busy_q;
    assign o_core_rst_n = core_rst_n_q;
    // masking with i_req suppresses any beat in the release cycle
    assign o_core_valid = |(gnt_q & i_valid & i_req);
    assign o_core_last  = |(gnt_q & i_last  & i_req);
    assign o_core_ack   = |(gnt_q & i_ack   & i_req);
    assign o_ready      = gnt_q & {NUM_REQ{i_core_ready}};
    assign o_valid      = gnt_q & {NUM_REQ{i_core_valid}};
    assign o_data       = i_core_data;
    assign o_squeeze    = i_core_squeeze;

endmodule

// File: doc/shake128_arbiter.md
# shake128_arbiter

Round-robin arbiter and job sequencer that shares one `shake128_top` core (64-bit absorb, 128-bit squeeze) between `NUM_REQ` requesters. It grants the core to one requester for a whole job, covering the absorb stream and then any number of squeeze blocks. Between jobs it pulses the core's active-low reset so every job starts from a clean Keccak state. It sits between the XOF clients (matrix sampler, PRF, KDF) and the single hash core.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `CLR_CYCLES`, 2: cycles `o_core_rst_n` is held low between jobs, ≥1.
- `TIMEOUT`, 1024: idle-grant limit in cycles. Used only with `SHAKE_ARB_TIMEOUT_EN`.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  NUM_REQ  per-requester request, held high for the whole job.
- `i_data`  in  NUM_REQ*64  absorb words; requester k uses `[64k+63:64k]`.
- `i_valid`  in  NUM_REQ  absorb word valid.
- `i_last`  in  NUM_REQ  last absorb word.
- `i_ack`  in  NUM_REQ  squeeze block consumed.
- `o_gnt`  out  NUM_REQ  one-hot grant, registered.
- `o_ready`  out  NUM_REQ  absorb ready (`o_gnt[k] & i_core_ready`).
- `o_data`  out  128  squeeze data, broadcast from the core.
- `o_valid`  out  NUM_REQ  squeeze valid (`o_gnt[k] & i_core_valid`).
- `o_squeeze`  out  1  core squeeze mode, broadcast.
- `o_busy`  out  1  high in GRANT or CLEAR.
- `o_timeout`  out  NUM_REQ  sticky timeout flags. Tied to 0 without the macro.
- `o_core_rst_n`  out  1  active-low reset to the core.
- `o_core_data`  out  64  to core `i_data`.
- `o_core_valid`  out  1  to core `i_valid`.
- `o_core_last`  out  1  to core `i_last`.
- `o_core_ack`  out  1  to core `i_ack`.
- `i_core_ready`, `i_core_data[127:0]`, `i_core_valid`, `i_core_squeeze`  in  from core.

## Operation
- **States:** CLEAR, ARB, GRANT.
- **Reset:** `i_rst` forces state CLEAR with the clear counter at `CLR_CYCLES`. All outputs take their reset values:
  - `o_gnt` = 0, `o_busy` = 0, `o_timeout` = 0.
  - All core-side drives = 0, including `o_core_rst_n` = 0.
- **CLEAR:**
  - `o_core_rst_n` = 0, `o_gnt` = 0; the counter decrements each cycle.
  - At counter = 1 the state goes to ARB.
  - CLEAR therefore lasts exactly `CLR_CYCLES` cycles.
- **ARB:**
  - `o_core_rst_n` = 1.
  - If `i_req` ≠ 0, pick the first set bit at or after the round-robin pointer `ptr`, wrapping modulo `NUM_REQ`.
  - Register `o_gnt`, set `ptr` = winner + 1 (wrap), and go to GRANT.
  - If no request is present, stay in ARB.
- **GRANT:**
  - Mux the granted requester's `i_data` onto `o_core_data`.
  - `o_core_valid` = `i_valid[g] & i_req[g]`; `o_core_last` = `i_last[g] & i_req[g]`; `o_core_ack` = `i_ack[g] & i_req[g]`.
  - Non-granted requesters see `o_ready`, `o_valid` = 0.
  - The core's own handshakes (`o_ready`/`i_valid`, `o_valid`/`i_ack`) pass through unchanged. The arbiter neither counts nor reorders beats.
- **Release:**
  - `i_req[g]` sampled low in GRANT → next cycle `o_gnt` = 0 and state CLEAR.
  - Any beat presented in the release cycle is masked, never forwarded.
  - Releasing mid-absorb or mid-squeeze is legal; the CLEAR pulse discards the core state.
- **Simultaneous events:**
  - A request rising during CLEAR waits for ARB.
  - Multiple requests in ARB resolve by `ptr` only.
  - A requester holding `i_req` is never preempted, except by timeout when the macro is enabled.

## Timing
- Request to grant: `i_req` rising while in ARB gives `o_gnt` high on the next edge (1 cycle).
- Release to next grant: `CLR_CYCLES` + 2 cycles (1 release edge, `CLR_CYCLES` in CLEAR, 1 ARB).
- All core-side and requester-side data/handshake paths are combinational from the `o_gnt` register; there is no added pipeline latency.
- `o_busy` and `o_gnt` are registered. `o_core_rst_n` is registered and glitch-free.
- First grant after reset deassertion: `CLR_CYCLES` + 1 cycles.

## Configuration
- **Macro `SHAKE_ARB_TIMEOUT_EN`.**
- **Defined:**
  - A counter of width `$clog2(TIMEOUT+1)` clears on every granted handshake: `o_core_valid & i_core_ready`, or `o_core_ack & i_core_valid`.
  - It increments in GRANT otherwise.
  - At `TIMEOUT` the arbiter sets `o_timeout[g]` (sticky until `i_rst`), drops the grant, and enters CLEAR exactly as on release.
  - The timed-out requester must drop and re-raise `i_req` before it can be granted again; until then it is masked in ARB.
- **Undefined:** there is no counter, `o_timeout` is constant 0, and a grant is held indefinitely.

## Test plan
- **Single job:** req0 absorbs `swap_endian(64'h1234567800000000)` with `i_last` → first 16 output bytes in byte order `57affc13ef3e6ff511f8914a0bbbc3b3`. After one `i_ack`, the next block is `cb44176616a8ce5111c4b77120263e95`.
- **Simultaneous requests:** `i_req` = 2'b11 after reset → req0 granted first. After req0 releases, `o_core_rst_n` is low for exactly 2 cycles, then req1 is granted 1 cycle later. Both jobs return correct digests.
- **Fairness:** req0 re-raises immediately after each release while req1 is held → grants alternate 0,1,0,1 across 4 jobs.
- **Mid-absorb release:** req1 drops `i_req` after 1 of 3 words → no further core beats. The next job on the same input yields the same digest as a clean single job.
- **Reset mid-grant:** pulse `i_rst` during a squeeze → the next cycle shows all outputs at reset values and `o_core_rst_n` = 0. The first grant comes `CLR_CYCLES` + 1 cycles after `i_rst` falls.
- **Timeout (macro on, `TIMEOUT` = 16):** granted req0 makes no handshake for 16 cycles → `o_timeout[0]` = 1, grant drops, and req1 is granted `CLR_CYCLES` + 2 cycles later.
